// File: rtl/demux_serial_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : demux_serial_feeder
//  Purpose  : Serialises channel-addressed words MSB-first into din/sel/enable
//             for a 1-to-8 demux, with an idle gap and a channel drop mask.
//             Optional even-parity bit: define DEMUX_FEEDER_PARITY_EN.
//  Revision : 1.0
// ============================================================================
module demux_serial_feeder #(
    parameter int          DATA_W     = 8,
    parameter int          GAP_CYCLES = 1,
    parameter logic [7:0]  CHAN_MASK  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_chan,
    input  logic [DATA_W-1:0] in_data,
    output logic              enable,
    output logic [2:0]        sel,
    output logic              din,
    output logic              busy,
    output logic              done,
    output logic              drop
);

`ifdef DEMUX_FEEDER_PARITY_EN
    localparam int c_NBITS = DATA_W + 1;
`else
    localparam int c_NBITS = DATA_W;
`endif
    localparam int c_CNT_W = $clog2(c_NBITS + 1);
    localparam int c_GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(c_NBITS - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_NBITS-1:0]   r_shreg;
    logic [2:0]           r_sel;
    logic [c_CNT_W-1:0]   r_bitcnt;
    logic [c_GAP_W-1:0]   r_gapcnt;
    logic                 r_done;
    logic                 r_drop;

    logic                 w_xfer;
    logic                 w_deliver;
    logic                 w_bit_last;
    logic                 w_gap_last;
    logic [c_NBITS-1:0]   w_frame;

    // Parity rides in the LSB so it leaves last after the payload.
`ifdef DEMUX_FEEDER_PARITY_EN
    assign w_frame = {in_data, ^in_data};
`else
    assign w_frame = in_data;
`endif

    assign w_xfer     = in_valid & in_ready;
    assign w_deliver  = CHAN_MASK[in_chan];
    assign w_bit_last = (r_bitcnt == c_BIT_LAST);
    assign w_gap_last = (r_gapcnt == c_GAP_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer && w_deliver) w_next = S_SHIFT;
            S_SHIFT: if (w_bit_last) w_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            S_GAP:   if (w_gap_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_sel    <= 3'b000;
            r_bitcnt <= '0;
            r_gapcnt <= '0;
            r_done   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (w_deliver) begin
                            r_shreg  <= w_frame;
                            r_sel    <= in_chan;
                            r_bitcnt <= '0;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_shreg  <= r_shreg << 1;
                    r_bitcnt <= r_bitcnt + c_CNT_W'(1);
                    if (w_bit_last) begin
                        r_done   <= 1'b1;
                        r_gapcnt <= '0;
                    end
                end
                S_GAP: begin
                    r_gapcnt <= r_gapcnt + c_GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Ready is withheld during the reset cycle so no word is lost to the reset edge.
    assign in_ready = (r_state == S_IDLE) && !rst;
    assign enable   = (r_state == S_SHIFT);
    assign sel      = r_sel;
    assign din      = enable & r_shreg[c_NBITS-1];
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign drop     = r_drop;

endmodule
`default_nettype wire
